// File: rtl/sample_capture.sv
// -----------------------------------------------------------------------------
// sample_capture
//
// Captures a programmed number of samples from a strobed, already-synchronized
// data stream into a FIFO. The FIFO drains through a valid/ready port.
// A three-state controller (IDLE, CAPTURE, DONE) counts the accepted strobes.
// The overflow flag records any sample that was dropped because the FIFO was
// full. It is sticky until the next accepted start.
//
// Ports
//   clk          in   fast-domain clock, rising edge
//   reset        in   synchronous, active-high reset
//   sync_data    in   [S-1:0] sample word
//   sample_en    in   strobe: sync_data is a new sample this cycle
//   start        in   pulse: arm a run of num_samples samples
//   num_samples  in   [15:0] samples per run, taken on the accepted start
//   abort        in   pulse: return to IDLE and flush the FIFO
//   out_data     out  [S-1:0] FIFO head word
//   out_valid    out  out_data holds a valid word
//   out_ready    in   consumer accepts the head word
//   busy         out  controller is in CAPTURE
//   done         out  controller is in DONE
//   overflow     out  sticky: a sample was dropped on a full FIFO
//   level        out  [clog2(DEPTH):0] FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sample_capture #(
   parameter int S     = 12,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [S-1:0]             sync_data,
   input  logic                     sample_en,
   input  logic                     start,
   input  logic [15:0]              num_samples,
   input  logic                     abort,
   output logic [S-1:0]             out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   state_e          state_q,     state_d;
   logic [15:0]     remaining_q, remaining_d;
   logic            overflow_q,  overflow_d;
   logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [LW-1:0]   level_q,     level_d;
   logic [S-1:0]    mem [DEPTH];

   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push_req;
   logic push;

   // Full and empty come from the occupancy count. The pointers can then wrap
   // freely without needing an extra bit to tell full from empty.
   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LW'(DEPTH));
   assign pop        = !fifo_empty && out_ready;
   // abort suppresses a same-cycle sample
   assign push_req   = (state_q == ST_CAPTURE) && sample_en && !abort;
   // A full FIFO can still accept a word when the head leaves on the same cycle.
   assign push       = push_req && (!fifo_full || pop);

   // NOTE: every always_comb target gets its hold value first, so no path can leave a latch.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      overflow_d  = overflow_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;

      if (abort) begin
         // Flush, but leave overflow alone so the consumer can still see it.
         state_d     = ST_IDLE;
         remaining_d = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  remaining_d = num_samples;
                  overflow_d  = 1'b0;
                  state_d     = (num_samples == 16'd0) ? ST_DONE : ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (push_req) begin
                  // A dropped sample still counts toward the run length.
                  remaining_d = remaining_q - 16'd1;
                  if (remaining_q == 16'd1) begin
                     state_d = ST_DONE;
                  end
                  if (!push) begin
                     overflow_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   // NOTE: the storage array has no reset; level_q and the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_q] <= sync_data;
      end
   end

   // Outputs are forced to zero while reset is high, including the cycle it is first raised.
   assign out_valid = !reset && !fifo_empty;
   assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
   assign busy      = !reset && (state_q == ST_CAPTURE);
   assign done      = !reset && (state_q == ST_DONE);
   assign overflow  = !reset && overflow_q;
   assign level     = reset ? '0 : level_q;

endmodule

// File: tb/tb_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_sample_capture
//
// Drives sample_capture with directed and randomized stimulus. A queue-based
// reference model runs alongside the DUT. Every cycle, on the falling edge,
// a compare process checks all DUT outputs against the model. The directed
// scenarios also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_sample_capture;

   localparam int S     = 12;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   localparam int P_IDLE = 0;
   localparam int P_CAP  = 1;
   localparam int P_DONE = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [S-1:0]    sync_data;
   logic            sample_en;
   logic            start;
   logic [15:0]     num_samples;
   logic            abort;
   logic [S-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic            busy;
   logic            done;
   logic            overflow;
   logic [LW-1:0]   level;

   always #5 clk = ~clk;

   sample_capture #(.S(S), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .sync_data  (sync_data),
      .sample_en  (sample_en),
      .start      (start),
      .num_samples(num_samples),
      .abort      (abort),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .level      (level)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   bit          compare_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [S-1:0] m_q[$];
   int           m_phase = P_IDLE;
   int           m_rem   = 0;
   bit           m_ovf   = 1'b0;

   always @(posedge clk) begin : model
      bit pop_now;
      if (reset) begin
         m_q.delete();
         m_phase = P_IDLE;
         m_rem   = 0;
         m_ovf   = 1'b0;
      end else if (abort) begin
         m_q.delete();
         m_phase = P_IDLE;
         m_rem   = 0;
      end else begin
         pop_now = (m_q.size() > 0) && out_ready;
         if (pop_now) void'(m_q.pop_front());
         if (m_phase == P_CAP && sample_en) begin
            if (m_q.size() < DEPTH) m_q.push_back(sync_data);
            else                    m_ovf = 1'b1;
            m_rem--;
            if (m_rem == 0) m_phase = P_DONE;
         end else if (start && m_phase != P_CAP) begin
            m_rem   = int'(num_samples);
            m_ovf   = 1'b0;
            m_phase = (num_samples == 16'd0) ? P_DONE : P_CAP;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (compare_en) begin
         if (reset) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data",  32'(out_data),  32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_done",      32'(done),      32'd0);
            check("rst_overflow",  32'(overflow),  32'd0);
            check("rst_level",     32'(level),     32'd0);
         end else begin
            check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
            check("level",    32'(level),    32'(m_q.size()));
            check("busy",     32'(busy),     32'(m_phase == P_CAP));
            check("done",     32'(done),     32'(m_phase == P_DONE));
            check("overflow", 32'(overflow), 32'(m_ovf));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [S-1:0] d);
      sample_en = 1'b1;
      sync_data = d;
      step();
      sample_en = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] n);
      start       = 1'b1;
      num_samples = n;
      step();
      start       = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      reset = 1'b1; sync_data = '0; sample_en = 1'b0; start = 1'b0;
      num_samples = '0; abort = 1'b0; out_ready = 1'b0;
      step();
      compare_en = 1'b1;
      step();
      reset = 1'b0;
      step();
      check("reset_level", 32'(level), 32'd0);
      check("reset_busy",  32'(busy),  32'd0);

      // Basic run: four samples, each visible one cycle after its push.
      out_ready = 1'b1;
      do_start(16'd4);
      check("basic_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         strobe(S'(i));
         check("basic_valid", 32'(out_valid), 32'd1);
         check("basic_data",  32'(out_data),  32'(i));
      end
      check("basic_done", 32'(done), 32'd1);
      check("basic_ovf",  32'(overflow), 32'd0);
      step();
      check("basic_drained", 32'(level), 32'd0);

      // Overflow: twenty samples into a sixteen-entry FIFO with no consumer.
      out_ready = 1'b0;
      do_start(16'd20);
      for (int i = 0; i < 20; i++) begin
         strobe(S'(12'h100 + i));
         if (i == 15) begin
            check("ovf_level16", 32'(level), 32'd16);
            check("ovf_not_yet", 32'(overflow), 32'd0);
         end
         if (i == 16) check("ovf_after17", 32'(overflow), 32'd1);
      end
      check("ovf_done",  32'(done),  32'd1);
      check("ovf_level", 32'(level), 32'd16);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_drain", 32'(out_data), 32'(12'h100 + i));
         step();
      end
      check("ovf_empty", 32'(level), 32'd0);

      // Full FIFO with a push and a pop on the same cycle.
      out_ready = 1'b0;
      do_start(16'd17);
      for (int i = 0; i < 16; i++) strobe(S'(12'h200 + i));
      check("fp_full", 32'(level), 32'd16);
      out_ready = 1'b1;
      strobe(12'hABC);
      out_ready = 1'b0;
      check("fp_level", 32'(level), 32'd16);
      check("fp_ovf",   32'(overflow), 32'd0);
      check("fp_head",  32'(out_data), 32'h201);
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) step();
      check("fp_tail", 32'(out_data), 32'hABC);
      step();

      // Zero-count start, then a start ignored during CAPTURE.
      do_start(16'd0);
      check("zero_done",  32'(done),  32'd1);
      check("zero_level", 32'(level), 32'd0);
      do_start(16'd6);
      strobe(12'h011);
      strobe(12'h012);
      do_start(16'd3);
      for (int i = 0; i < 3; i++) strobe(S'(12'h013 + i));
      check("ign_busy", 32'(busy), 32'd1);
      strobe(12'h016);
      check("ign_done", 32'(done), 32'd1);
      step();

      // Abort after 2 of 5 samples; the abort-cycle sample is not pushed.
      out_ready = 1'b0;
      do_start(16'd5);
      strobe(12'h021);
      strobe(12'h022);
      abort = 1'b1; sample_en = 1'b1; sync_data = 12'h023;
      step();
      abort = 1'b0; sample_en = 1'b0;
      check("abort_busy",  32'(busy),      32'd0);
      check("abort_done",  32'(done),      32'd0);
      check("abort_level", 32'(level),     32'd0);
      check("abort_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) strobe(S'(12'h030 + i));
      check("abort_nopush", 32'(level), 32'd0);

      // Randomized backpressure over a 100-sample run.
      do_start(16'd100);
      cyc = 0;
      while (!done && cyc < 3000) begin
         sample_en = 1'($urandom_range(0, 1));
         sync_data = S'($urandom_range(0, 4095));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         cyc++;
      end
      sample_en = 1'b0;
      check("rand_run_done", 32'(done), 32'd1);

      // Reset in the middle of a run.
      out_ready = 1'b0;
      do_start(16'd50);
      for (int i = 0; i < 10; i++) strobe(S'($urandom_range(0, 4095)));
      reset = 1'b1;
      step();
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_data",  32'(out_data),  32'd0);
      check("midrst_busy",  32'(busy),      32'd0);
      check("midrst_level", 32'(level),     32'd0);
      reset = 1'b0;
      step();
      check("postrst_level", 32'(level), 32'd0);
      check("postrst_busy",  32'(busy),  32'd0);

      // Free-running random phase with every control input exercised.
      for (int i = 0; i < 800; i++) begin
         start       = ($urandom_range(0, 19) == 0);
         num_samples = 16'($urandom_range(0, 24));
         abort       = ($urandom_range(0, 59) == 0);
         reset       = ($urandom_range(0, 249) == 0);
         sample_en   = 1'($urandom_range(0, 1));
         sync_data   = S'($urandom_range(0, 4095));
         out_ready   = ($urandom_range(0, 2) == 0);
         step();
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0; sample_en = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
